// File: rtl/eth_mii_rx_framer_if.sv
// MII receive pins plus the framed byte stream and end-of-frame status.
// The framer drives through the master modport; its consumer uses slave.
interface eth_mii_rx_framer_if #(
  parameter int LEN_W = 11
);
  logic [3:0]       eth_mii_rxd;
  logic             eth_mii_rx_dv;
  logic [7:0]       rx_byte;
  logic             rx_byte_valid;
  logic             rx_sof;
  logic             rx_eof;
  logic             rx_frame_good;
  logic             rx_err_crc;
  logic             rx_err_len;
  logic             rx_err_align;
  logic [LEN_W-1:0] rx_frame_len;

  modport master (
    input  eth_mii_rxd, eth_mii_rx_dv,
    output rx_byte, rx_byte_valid, rx_sof, rx_eof, rx_frame_good,
           rx_err_crc, rx_err_len, rx_err_align, rx_frame_len
  );

  modport slave (
    output eth_mii_rxd, eth_mii_rx_dv,
    input  rx_byte, rx_byte_valid, rx_sof, rx_eof, rx_frame_good,
           rx_err_crc, rx_err_len, rx_err_align, rx_frame_len
  );
endinterface

// File: rtl/eth_mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, packs nibbles into bytes (low first),
// and reports length, CRC-32 and alignment status with the last byte.
//
// state    | meaning
// DROP     | ignore traffic until rx_dv falls (reset exit, bad preamble)
// IDLE     | line quiet, waiting for the first 0x5 nibble
// PREAMBLE | counting 0x5 nibbles, waiting for the 0xD SFD
// DATA     | packing nibbles into bytes until rx_dv falls
module eth_mii_rx_framer #(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int LEN_W           = 11
) (
  input  logic                eth_mac_clock,
  input  logic                eth_mac_rstn,
  eth_mii_rx_framer_if.master bus
);

  localparam logic [31:0]      CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [LEN_W-1:0] LEN_MIN     = LEN_W'(MIN_FRAME_BYTES);
  localparam logic [LEN_W-1:0] LEN_MAX     = LEN_W'(MAX_FRAME_BYTES);
  localparam logic [LEN_W-1:0] LEN_SAT     = {LEN_W{1'b1}};

  typedef enum logic [1:0] {ST_DROP, ST_IDLE, ST_PREAMBLE, ST_DATA} state_t;

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

  state_t           state, state_nxt;
  logic             half_q, half_nxt;
  logic [3:0]       low_q, low_nxt;
  logic [7:0]       hold_q, hold_nxt;
  logic             full_q, full_nxt;
  logic             sof_pend_q, sof_pend_nxt;
  logic             eof_pend_q, eof_pend_nxt;
  logic [31:0]      crc_q, crc_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;

  logic [7:0]       byte_q, byte_nxt;
  logic             valid_q, valid_nxt;
  logic             sof_q, sof_nxt;
  logic             eof_q, eof_nxt;
  logic             good_q, good_nxt;
  logic             ecrc_q, ecrc_nxt;
  logic             elen_q, elen_nxt;
  logic             ealign_q, ealign_nxt;
  logic [LEN_W-1:0] flen_q, flen_nxt;

  logic [7:0]       new_byte;
  logic             crc_bad, len_bad;
  logic             fin, fin_align;

  assign new_byte = {bus.eth_mii_rxd, low_q};
  assign crc_bad  = (crc_q != CRC_RESIDUE);
  assign len_bad  = (len_q < LEN_MIN) || (len_q > LEN_MAX);

  always_ff @(posedge eth_mac_clock or negedge eth_mac_rstn) begin
    if (!eth_mac_rstn) begin
      state      <= ST_DROP;
      half_q     <= 1'b0;
      low_q      <= 4'h0;
      hold_q     <= 8'h00;
      full_q     <= 1'b0;
      sof_pend_q <= 1'b0;
      eof_pend_q <= 1'b0;
      crc_q      <= 32'hFFFFFFFF;
      len_q      <= '0;
      byte_q     <= 8'h00;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      good_q     <= 1'b0;
      ecrc_q     <= 1'b0;
      elen_q     <= 1'b0;
      ealign_q   <= 1'b0;
      flen_q     <= '0;
    end else begin
      state      <= state_nxt;
      half_q     <= half_nxt;
      low_q      <= low_nxt;
      hold_q     <= hold_nxt;
      full_q     <= full_nxt;
      sof_pend_q <= sof_pend_nxt;
      eof_pend_q <= eof_pend_nxt;
      crc_q      <= crc_nxt;
      len_q      <= len_nxt;
      byte_q     <= byte_nxt;
      valid_q    <= valid_nxt;
      sof_q      <= sof_nxt;
      eof_q      <= eof_nxt;
      good_q     <= good_nxt;
      ecrc_q     <= ecrc_nxt;
      elen_q     <= elen_nxt;
      ealign_q   <= ealign_nxt;
      flen_q     <= flen_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    half_nxt     = half_q;
    low_nxt      = low_q;
    hold_nxt     = hold_q;
    full_nxt     = full_q;
    sof_pend_nxt = sof_pend_q;
    eof_pend_nxt = 1'b0;
    crc_nxt      = crc_q;
    len_nxt      = len_q;
    byte_nxt     = byte_q;
    valid_nxt    = 1'b0;
    sof_nxt      = 1'b0;
    eof_nxt      = 1'b0;
    good_nxt     = 1'b0;
    ecrc_nxt     = 1'b0;
    elen_nxt     = 1'b0;
    ealign_nxt   = 1'b0;
    flen_nxt     = '0;
    fin          = 1'b0;
    fin_align    = 1'b0;

    // Even-aligned frame end: the last byte completed one edge before rx_dv
    // fell, so its eof strobe is held back a cycle to keep byte spacing at two.
    if (eof_pend_q) begin
      fin      = 1'b1;
      full_nxt = 1'b0;
    end

    case (state)
      ST_DROP: begin
        if (!bus.eth_mii_rx_dv) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.eth_mii_rx_dv)
          state_nxt = (bus.eth_mii_rxd == 4'h5) ? ST_PREAMBLE : ST_DROP;
      end
      ST_PREAMBLE: begin
        if (!bus.eth_mii_rx_dv) begin
          state_nxt = ST_IDLE;
        end else if (bus.eth_mii_rxd == 4'hD) begin
          state_nxt    = ST_DATA;
          half_nxt     = 1'b0;
          full_nxt     = 1'b0;
          sof_pend_nxt = 1'b1;
          crc_nxt      = 32'hFFFFFFFF;
          len_nxt      = '0;
        end else if (bus.eth_mii_rxd != 4'h5) begin
          state_nxt = ST_DROP;
        end
      end
      ST_DATA: begin
        if (bus.eth_mii_rx_dv) begin
          if (!half_q) begin
            low_nxt  = bus.eth_mii_rxd;
            half_nxt = 1'b1;
          end else begin
            half_nxt = 1'b0;
            if (full_q) begin
              valid_nxt    = 1'b1;
              byte_nxt     = hold_q;
              sof_nxt      = sof_pend_q;
              sof_pend_nxt = 1'b0;
            end
            hold_nxt = new_byte;
            full_nxt = 1'b1;
            crc_nxt  = crc_byte(crc_q, new_byte);
            if (len_q != LEN_SAT) len_nxt = len_q + LEN_W'(1);
          end
        end else begin
          state_nxt = ST_IDLE;
          half_nxt  = 1'b0;
          if (full_q) begin
            if (half_q) begin
              fin       = 1'b1;
              fin_align = 1'b1;
              full_nxt  = 1'b0;
            end else begin
              eof_pend_nxt = 1'b1;
            end
          end
        end
      end
      default: state_nxt = ST_DROP;
    endcase

    if (fin) begin
      valid_nxt    = 1'b1;
      byte_nxt     = hold_q;
      sof_nxt      = sof_pend_q;
      sof_pend_nxt = 1'b0;
      eof_nxt      = 1'b1;
      ecrc_nxt     = crc_bad;
      elen_nxt     = len_bad;
      ealign_nxt   = fin_align;
      good_nxt     = ~(crc_bad | len_bad | fin_align);
      flen_nxt     = len_q;
    end
  end

  assign bus.rx_byte       = byte_q;
  assign bus.rx_byte_valid = valid_q;
  assign bus.rx_sof        = sof_q;
  assign bus.rx_eof        = eof_q;
  assign bus.rx_frame_good = good_q;
  assign bus.rx_err_crc    = ecrc_q;
  assign bus.rx_err_len    = elen_q;
  assign bus.rx_err_align  = ealign_q;
  assign bus.rx_frame_len  = flen_q;

endmodule
